// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the MAC TX byte stream.
// Source 0 is the RX-to-TX loopback FIFO and source 1 is the local generator.
// A granted source owns the output until tlast. Frames longer than MAX_LEN
// get a forced tlast, and their tail is drained so the MAC never stalls.
// Every frame is followed by IFG_CYCLES idle cycles.
module eth_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic [1:0]            o_grant,
    output logic                  o_trunc
);

    localparam int unsigned CntW = ($clog2(MAX_LEN + 1) > 1) ? $clog2(MAX_LEN + 1) : 1;
    localparam int unsigned GapW = ($clog2(IFG_CYCLES + 1) > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    // Count value seen on the MAX_LEN-th beat of a frame.
    localparam logic [CntW-1:0] TruncCnt = CntW'(MAX_LEN - 1);
    localparam logic [CntW-1:0] SatCnt   = CntW'(MAX_LEN);
    localparam int unsigned     GapLastI = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
    localparam logic [GapW-1:0] GapLast  = GapW'(GapLastI);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StDrain,
        StGap
    } state_e;

    // A zero gap goes straight back to arbitration.
    localparam state_e EndState = (IFG_CYCLES == 0) ? StIdle : StGap;

    state_e          state_q;
    logic            sel_q;
    logic            last_grant_q;
    logic [CntW-1:0] cnt_q;
    logic [GapW-1:0] gap_q;
    logic [1:0]      grant_q;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic                  sel_tready;
    logic                  arb_valid;
    logic                  arb_sel;
    logic                  at_limit;
    logic                  xfer_hs;
    logic                  drain_hs;
    logic                  trunc;

    // Mux the currently owned source and resolve the next owner.
    always_comb begin
        sel_tdata  = sel_q ? s1_axis_tdata  : s0_axis_tdata;
        sel_tvalid = sel_q ? s1_axis_tvalid : s0_axis_tvalid;
        sel_tlast  = sel_q ? s1_axis_tlast  : s0_axis_tlast;

        arb_valid  = s0_axis_tvalid | s1_axis_tvalid;
        // On a tie the source that did not win last time is chosen.
        if (s0_axis_tvalid && s1_axis_tvalid) begin
            arb_sel = ~last_grant_q;
        end else begin
            arb_sel = s1_axis_tvalid;
        end

        at_limit = (cnt_q == TruncCnt);
        xfer_hs  = (state_q == StXfer) && sel_tvalid && m_axis_tready;
        drain_hs = (state_q == StDrain) && sel_tvalid;
        // A tlast on the limit beat is a normal end of frame.
        trunc    = xfer_hs && !sel_tlast && at_limit;
    end

    // Output steering: passthrough in XFER, sink-only in DRAIN, silent otherwise.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        sel_tready    = 1'b0;
        unique case (state_q)
            StXfer: begin
                m_axis_tdata  = sel_tdata;
                m_axis_tvalid = sel_tvalid;
                m_axis_tlast  = sel_tlast | at_limit;
                sel_tready    = m_axis_tready;
            end
            StDrain: begin
                sel_tready    = 1'b1;
            end
            StIdle, StGap: begin
                sel_tready    = 1'b0;
            end
            default: begin
                sel_tready    = 1'b0;
            end
        endcase
        s0_axis_tready = sel_tready & ~sel_q;
        s1_axis_tready = sel_tready &  sel_q;
        o_trunc        = trunc;
        o_grant        = grant_q;
    end

    // Frame FSM: ownership, byte count, idle gap and registered grant.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            gap_q        <= '0;
            grant_q      <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        sel_q        <= arb_sel;
                        last_grant_q <= arb_sel;
                        cnt_q        <= '0;
                        grant_q      <= arb_sel ? 2'b10 : 2'b01;
                        state_q      <= StXfer;
                    end
                end
                StXfer: begin
                    if (xfer_hs) begin
                        if (cnt_q != SatCnt) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (sel_tlast) begin
                            grant_q <= 2'b00;
                            gap_q   <= '0;
                            state_q <= EndState;
                        end else if (at_limit) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_hs && sel_tlast) begin
                        grant_q <= 2'b00;
                        gap_q   <= '0;
                        state_q <= EndState;
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Ownership is exclusive and the output only carries data under a grant.
    a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_grant));
    a_valid_granted: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        m_axis_tvalid |-> (o_grant != 2'b00));

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter. Instance A uses IFG_CYCLES=12, MAX_LEN=1518 and
// instance B uses IFG_CYCLES=0, MAX_LEN=16. Sources are modelled as beat
// queues; expected output beats go into a per-instance scoreboard.
module tb_eth_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Source index: 0/1 = instance A s0/s1, 2/3 = instance B s0/s1.
    logic [3:0][7:0] s_tdata;
    logic [3:0]      s_tvalid;
    logic [3:0]      s_tlast;
    logic [3:0]      s_tready;
    logic [1:0][7:0] m_tdata;
    logic [1:0]      m_tvalid;
    logic [1:0]      m_tlast;
    logic [1:0]      m_tready;
    logic [1:0][1:0] grant;
    logic [1:0]      trunc;

    eth_tx_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(12), .MAX_LEN(1518)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .s0_axis_tdata(s_tdata[0]), .s0_axis_tvalid(s_tvalid[0]),
        .s0_axis_tlast(s_tlast[0]), .s0_axis_tready(s_tready[0]),
        .s1_axis_tdata(s_tdata[1]), .s1_axis_tvalid(s_tvalid[1]),
        .s1_axis_tlast(s_tlast[1]), .s1_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready[0]),
        .o_grant(grant[0]), .o_trunc(trunc[0])
    );

    eth_tx_arbiter #(.DATA_WIDTH(8), .IFG_CYCLES(0), .MAX_LEN(16)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .s0_axis_tdata(s_tdata[2]), .s0_axis_tvalid(s_tvalid[2]),
        .s0_axis_tlast(s_tlast[2]), .s0_axis_tready(s_tready[2]),
        .s1_axis_tdata(s_tdata[3]), .s1_axis_tvalid(s_tvalid[3]),
        .s1_axis_tlast(s_tlast[3]), .s1_axis_tready(s_tready[3]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready[1]),
        .o_grant(grant[1]), .o_trunc(trunc[1])
    );

    logic [8:0]  src_q [4][$];   // {tlast, tdata}
    logic [10:0] sb_q  [2][$];   // {source, tlast, tdata}
    int          gap_q [2][$];   // idle cycles between a tlast and the next tvalid

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [3:0] hs_pend;
    logic [1:0] in_gap;
    logic [1:0] prev_mvalid;
    logic [1:0] rand_ready;
    logic       mirror_chk;
    int   idle_run  [2];
    int   rise_cyc  [2];
    int   beat_cnt  [2];
    int   trunc_cnt [2];
    int   start_cyc [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue one frame of n bytes on source i; only the first n_out reach the MAC.
    task automatic send(input int i, input int n, input logic [7:0] base, input int n_out);
        logic [7:0] d;
        logic [1:0] src;
        src = 2'(i % 2);
        for (int b = 0; b < n; b++) begin
            d = base + 8'(b);
            src_q[i].push_back({(b == n - 1), d});
            if (b < n_out) begin
                sb_q[i / 2].push_back({src, (b == n_out - 1), d});
            end
        end
    endtask

    task automatic monitor(input int k);
        logic [10:0] obs;
        logic [10:0] exp;
        logic [1:0]  src;
        if (trunc[k]) trunc_cnt[k]++;
        if (m_tvalid[k]) begin
            if (!prev_mvalid[k]) rise_cyc[k] = cyc;
            if (in_gap[k]) begin
                gap_q[k].push_back(idle_run[k]);
                in_gap[k] = 1'b0;
            end
            if (m_tready[k]) begin
                src = (grant[k] == 2'b01) ? 2'd0 : (grant[k] == 2'b10) ? 2'd1 : 2'd3;
                obs = {src, m_tlast[k], m_tdata[k]};
                if (sb_q[k].size() == 0) begin
                    check(k == 0 ? "a_extra_beat" : "b_extra_beat", 32'(obs), 32'hffff_ffff);
                end else begin
                    exp = sb_q[k].pop_front();
                    check(k == 0 ? "a_beat" : "b_beat", 32'(obs), 32'(exp));
                end
                beat_cnt[k]++;
                if (m_tlast[k]) begin
                    in_gap[k]   = 1'b1;
                    idle_run[k] = 0;
                end
            end
        end else if (in_gap[k]) begin
            idle_run[k]++;
        end
        if (mirror_chk && k == 0 && grant[0] == 2'b10) begin
            check("s1_ready_mirror", 32'(s_tready[1]), 32'(m_tready[0]));
            check("s0_ready_low", 32'(s_tready[0]), 32'd0);
        end
        prev_mvalid[k] = m_tvalid[k];
    endtask

    // Drive sources on the falling edge, sample handshakes and outputs 1 ns later.
    initial begin : drive_and_monitor
        logic [8:0] head;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (hs_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                hs_pend[i] = 1'b0;
                if (src_q[i].size() > 0) begin
                    head = src_q[i][0];
                    if (!s_tvalid[i]) start_cyc[i] = cyc;
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = head[7:0];
                    s_tlast[i]  = head[8];
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdata[i]  = '0;
                    s_tlast[i]  = 1'b0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                m_tready[k] = rand_ready[k] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            for (int i = 0; i < 4; i++) hs_pend[i] = s_tvalid[i] & s_tready[i];
            for (int k = 0; k < 2; k++) monitor(k);
        end
    end

    task automatic wait_done(input int k, input int budget, input int settle);
        int n;
        n = 0;
        while ((sb_q[k].size() > 0 || src_q[2 * k].size() > 0 || src_q[2 * k + 1].size() > 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("timeout_pending_beats", 32'(sb_q[k].size()), 32'd0);
        repeat (settle) @(negedge clk);
    endtask

    task automatic clear_gaps(input int k);
        gap_q[k].delete();
        in_gap[k] = 1'b0;
    endtask

    task automatic check_reset_outputs(input int k);
        check("rst_m_tvalid", 32'(m_tvalid[k]), 32'd0);
        check("rst_m_tlast", 32'(m_tlast[k]), 32'd0);
        check("rst_m_tdata", 32'(m_tdata[k]), 32'd0);
        check("rst_grant", 32'(grant[k]), 32'd0);
        check("rst_trunc", 32'(trunc[k]), 32'd0);
        check("rst_s0_tready", 32'(s_tready[2 * k]), 32'd0);
        check("rst_s1_tready", 32'(s_tready[2 * k + 1]), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

    initial begin : main
        int b0;
        int n;
        rst_n = 1'b0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = '1;
        hs_pend = '0; in_gap = '0; prev_mvalid = '0; rand_ready = '0; mirror_chk = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_run[k] = 0; rise_cyc[k] = 0; beat_cnt[k] = 0; trunc_cnt[k] = 0;
        end
        for (int i = 0; i < 4; i++) start_cyc[i] = 0;

        // Reset state, with a request pending on each source.
        s_tvalid = '1;
        repeat (3) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) check_reset_outputs(k);
        #1 rst_n = 1'b1;

        // A: both sources request continuously with 10-byte frames.
        @(negedge clk); #2;
        clear_gaps(0);
        send(0, 10, 8'h10, 10);
        send(1, 10, 8'h20, 10);
        send(0, 10, 8'h30, 10);
        send(1, 10, 8'h40, 10);
        wait_done(0, 400, 20);
        check("rr_gap_count", 32'(gap_q[0].size()), 32'd3);
        while (gap_q[0].size() > 0) check("rr_gap_len", 32'(gap_q[0].pop_front()), 32'd13);

        // A: single 64-byte frame from s0, arbitration latency of one cycle.
        clear_gaps(0);
        b0 = beat_cnt[0];
        send(0, 64, 8'h00, 64);
        wait_done(0, 400, 20);
        check("single_beats", 32'(beat_cnt[0] - b0), 32'd64);
        check("single_latency", 32'(rise_cyc[0] - start_cyc[0]), 32'd1);

        // A: 100-byte s1 frame under 50% random backpressure.
        rand_ready[0] = 1'b1;
        mirror_chk    = 1'b1;
        b0 = beat_cnt[0];
        send(1, 100, 8'h80, 100);
        wait_done(0, 2000, 2);
        rand_ready[0] = 1'b0;
        mirror_chk    = 1'b0;
        check("bp_beats", 32'(beat_cnt[0] - b0), 32'd100);
        repeat (20) @(negedge clk);

        // B: 40-byte s0 frame truncated to 16, then an intact s1 frame.
        trunc_cnt[1] = 0;
        send(2, 40, 8'h00, 16);
        send(3, 8, 8'hA0, 8);
        wait_done(1, 400, 5);
        check("trunc_pulses", 32'(trunc_cnt[1]), 32'd1);
        check("drain_consumed", 32'(src_q[2].size()), 32'd0);

        // B: exactly MAX_LEN bytes passes untouched; frames one cycle apart.
        trunc_cnt[1] = 0;
        clear_gaps(1);
        send(2, 16, 8'h40, 16);
        send(3, 16, 8'h60, 16);
        wait_done(1, 400, 5);
        check("boundary_no_trunc", 32'(trunc_cnt[1]), 32'd0);
        check("b2b_gap_count", 32'(gap_q[1].size()), 32'd1);
        if (gap_q[1].size() > 0) check("b2b_gap_len", 32'(gap_q[1].pop_front()), 32'd1);
        // Leave B with source 0 as last owner so the post-reset tie is telling.
        send(2, 4, 8'h70, 4);
        wait_done(1, 100, 5);

        // A: reset after 5 bytes of an s1 frame.
        b0 = beat_cnt[0];
        send(1, 20, 8'h90, 20);
        n = 0;
        while (beat_cnt[0] - b0 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("timeout_mid_frame", 32'(beat_cnt[0] - b0), 32'd5);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        for (int k = 0; k < 2; k++) begin
            sb_q[k].delete();
            clear_gaps(k);
        end
        hs_pend = '0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk); #2;
        send(0, 4, 8'hC0, 4);
        send(1, 4, 8'hD0, 4);
        send(2, 4, 8'hE0, 4);
        send(3, 4, 8'hF0, 4);
        wait_done(0, 200, 2);
        wait_done(1, 200, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single MAC TX AXI-Stream byte path between two requesters:
  - source 0: the RX-to-TX feedback/loopback FIFO;
  - source 1: the local packet generator or UDP stack.
- Once a source is granted, its frame is locked through until tlast, followed by a programmable idle gap.
- Frames longer than MAX_LEN are truncated and their tail is drained, so the MAC never stalls on a runaway frame.
- Sits directly upstream of the TX MAC inside ethernet_mac_project_top.

Parameters:
- DATA_WIDTH, 8, stream byte width.
- IFG_CYCLES, 12, idle cycles inserted after every frame. 0 means no gap.
- MAX_LEN, 1518, maximum bytes per frame before forced truncation. Must be at least 2.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- s0_axis_tdata  in  DATA_WIDTH  source 0 byte
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tlast  in  1  source 0 last byte of frame
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata  in  DATA_WIDTH  source 1 byte
- s1_axis_tvalid  in  1  source 1 valid
- s1_axis_tlast  in  1  source 1 last byte
- s1_axis_tready  out  1  source 1 ready
- m_axis_tdata  out  DATA_WIDTH  byte to MAC
- m_axis_tvalid  out  1  valid to MAC
- m_axis_tlast  out  1  last to MAC (also forced on truncation)
- m_axis_tready  in  1  MAC ready
- o_grant  out  2  one-hot current owner; 00 when idle
- o_trunc  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low (i_reset_n). All state is reset asynchronously.
  - While in reset: state=IDLE, o_grant=00, o_trunc=0, all tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - last_grant resets to 1, so source 0 wins the first tie.
- States: IDLE, XFER, DRAIN, GAP.
- IDLE:
  - Outputs inactive.
  - If exactly one sX_tvalid=1, grant that source. If both are valid, grant the source that is not last_grant.
  - On the next edge: sel is registered, last_grant<=sel, byte count<=0, state goes to XFER.
  - Arbitration latency is one cycle from tvalid to the first possible m_axis_tvalid.
- XFER:
  - Combinational passthrough: m_axis_tdata/tvalid/tlast = s_sel signals, and s_sel_tready = m_axis_tready. The non-selected tready=0.
  - On each handshake (m_axis_tvalid and m_axis_tready), count increments.
  - Handshake with tlast=1 → GAP, or → IDLE if IFG_CYCLES=0.
  - Handshake with count==MAX_LEN-1 and tlast=0:
    - m_axis_tlast is forced to 1 on that beat.
    - o_trunc pulses for that cycle.
    - State → DRAIN.
  - A deasserted s_sel_tvalid mid-frame simply stalls the transfer. There is no timeout and grant is held.
- DRAIN:
  - m_axis_tvalid=0, s_sel_tready=1. Bytes are discarded.
  - Handshake on s_sel with tlast=1 → GAP (or IDLE if IFG_CYCLES=0).
- GAP:
  - Outputs inactive, o_grant=00. Counter runs IFG_CYCLES cycles, then → IDLE.
  - Requests arriving during GAP are held by the sources and arbitrated in IDLE.
  - Minimum frame-to-frame spacing on m_axis: IFG_CYCLES+1 idle cycles (gap plus the arbitration cycle).
- o_grant is one-hot of sel while in XFER or DRAIN, and 00 otherwise.
- Counter widths: $clog2(MAX_LEN+1) and $clog2(IFG_CYCLES+1), minimum 1 bit each. The byte counter saturates; it never wraps.
- Simultaneous events:
  - tlast on the MAX_LEN-th byte is a normal end of frame: no o_trunc, no DRAIN.
  - A request from the other source during XFER never preempts the current frame.
- Reset asserted mid-frame: the frame is abandoned immediately, outputs go to their reset values, and the next grant after reset goes to source 0 on a tie.

Test Plan:
- Single source: s0 sends a 64-byte frame 0x00..0x3F, m_tready=1 → m_axis carries identical bytes, tlast on byte 64, o_grant=01 throughout, first m_tvalid one cycle after s0_tvalid.
- Both sources request continuously with 10-byte frames, IFG_CYCLES=12 → output order s0,s1,s0,s1; exactly 13 idle cycles between each tlast and the next tvalid; no byte interleaving.
- Backpressure: random m_tready at 50% on a 100-byte s1 frame → all 100 bytes arrive in order; s1_tready mirrors m_tready; s0_tready stays 0.
- Truncation with MAX_LEN=16: s0 sends 40 bytes → m_axis shows 16 bytes, tlast on the 16th, one-cycle o_trunc; the remaining 24 bytes are accepted and discarded; the next s1 frame is passed intact.
- Boundary: a frame of exactly MAX_LEN=16 bytes with tlast on byte 16 → passed with no o_trunc; IFG_CYCLES=0 gives back-to-back frames separated by exactly one arbitration cycle.
- Reset mid-frame: assert i_reset_n=0 after 5 bytes of an s1 frame → outputs go to zero asynchronously. After release, with both sources valid, source 0 is granted first.
